// File: rtl/opb_register_bank_if.sv
// OPB bus signals between a bus master and the register bank slave.
// Vectors keep OPB big-endian numbering: bit 0 is the MSB.
interface opb_register_bank_if;
    logic [0:31] OPB_ABus;
    logic [0:3]  OPB_BE;
    logic [0:31] OPB_DBus;
    logic        OPB_RNW;
    logic        OPB_select;
    logic        OPB_seqAddr;

    logic [0:31] Sl_DBus;
    logic        Sl_xferAck;
    logic        Sl_errAck;
    logic        Sl_retry;
    logic        Sl_toutSup;

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );
endinterface

// File: rtl/opb_register_bank.sv
// OPB slave exposing C_NUM_REGS 32-bit registers, each either software-written into fabric
// or fabric-driven and read by software, with byte enables, wait states and error ack.
module opb_register_bank #(
    parameter logic [31:0] C_BASEADDR  = 32'h0100_0000,
    parameter logic [31:0] C_HIGHADDR  = 32'h0100_00FF,
    parameter int unsigned C_NUM_REGS  = 4,
    parameter logic [15:0] C_DIR_MASK  = 16'h0000,
    parameter logic [31:0] C_RESET_VAL = 32'h0000_0000,
    parameter int unsigned C_ACK_WAIT  = 0
) (
    input  logic                      OPB_Clk,
    input  logic                      OPB_Rst_n,
    opb_register_bank_if.slave        bus,
    output logic [32*C_NUM_REGS-1:0]  user_data_out,
    input  logic [32*C_NUM_REGS-1:0]  user_data_in,
    output logic [C_NUM_REGS-1:0]     user_wr_strb
);

    typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

    state_e                  state_q;
    logic [1:0]              wait_cnt_q;
    logic [3:0]              idx_q;
    logic                    rnw_q;
    logic                    err_q;
    logic [3:0]              be_q;
    logic [31:0]             wdata_q;
    logic [31:0]             snap_q;
    logic [31:0]             regs_q [C_NUM_REGS];
    logic                    xfer_ack_q;
    logic                    err_ack_q;
    logic                    tout_sup_q;
    logic [31:0]             rdata_q;
    logic [C_NUM_REGS-1:0]   strb_q;

    logic [31:0] abus;
    logic [31:0] idx_full;
    logic [31:0] live_snap;
    logic [31:0] live_wdata;
    logic [3:0]  live_be;
    logic        hit;
    logic        live_err;

    // Live decode of the bus; [0:31] -> [31:0] puts DBus[0:7] on bits 31:24, BE[0] on bit 3.
    always_comb begin
        abus       = bus.OPB_ABus;
        live_be    = bus.OPB_BE;
        live_wdata = bus.OPB_DBus;
        idx_full   = (abus - C_BASEADDR) >> 2;
        hit        = bus.OPB_select && (abus >= C_BASEADDR) && (abus <= C_HIGHADDR);
        live_err   = (idx_full >= 32'(C_NUM_REGS)) ||
                     (!bus.OPB_RNW && C_DIR_MASK[idx_full[3:0]]);
        live_snap  = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (idx_full[3:0] == 4'(i)) live_snap = user_data_in[32*i +: 32];
        end
    end

    logic [3:0]  cur_idx;
    logic [3:0]  cur_be;
    logic        cur_rnw;
    logic        cur_err;
    logic [31:0] cur_wdata;
    logic [31:0] cur_snap;
    logic [31:0] cur_rdata;
    logic        enter_ack;

    // With no wait states the ack is issued straight from IDLE, so use the live bus there.
    always_comb begin
        if (state_q == StIdle) begin
            cur_idx   = idx_full[3:0];
            cur_be    = live_be;
            cur_rnw   = bus.OPB_RNW;
            cur_err   = live_err;
            cur_wdata = live_wdata;
            cur_snap  = live_snap;
        end else begin
            cur_idx   = idx_q;
            cur_be    = be_q;
            cur_rnw   = rnw_q;
            cur_err   = err_q;
            cur_wdata = wdata_q;
            cur_snap  = snap_q;
        end
        cur_rdata = '0;
        if (cur_rnw && !cur_err) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                if (cur_idx == 4'(i)) cur_rdata = C_DIR_MASK[4'(i)] ? cur_snap : regs_q[i];
            end
        end
        enter_ack = ((state_q == StIdle) && hit && (C_ACK_WAIT == 0)) ||
                    ((state_q == StWait) && bus.OPB_select && (wait_cnt_q == 2'd0));
    end

    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
            idx_q      <= '0;
            rnw_q      <= 1'b0;
            err_q      <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
            snap_q     <= '0;
            xfer_ack_q <= 1'b0;
            err_ack_q  <= 1'b0;
            tout_sup_q <= 1'b0;
            rdata_q    <= '0;
            strb_q     <= '0;
            for (int i = 0; i < C_NUM_REGS; i++) begin
                regs_q[i] <= C_DIR_MASK[4'(i)] ? 32'h0 : C_RESET_VAL;
            end
        end else begin
            xfer_ack_q <= enter_ack;
            err_ack_q  <= enter_ack && cur_err;
            rdata_q    <= enter_ack ? cur_rdata : 32'h0;
            strb_q     <= '0;

            unique case (state_q)
                StIdle: begin
                    if (hit) begin
                        idx_q   <= idx_full[3:0];
                        rnw_q   <= bus.OPB_RNW;
                        err_q   <= live_err;
                        be_q    <= live_be;
                        wdata_q <= live_wdata;
                        snap_q  <= live_snap;
                        if (C_ACK_WAIT > 0) begin
                            state_q    <= StWait;
                            wait_cnt_q <= 2'(C_ACK_WAIT - 1);
                            tout_sup_q <= 1'b1;
                        end else begin
                            state_q <= StAck;
                        end
                    end
                end
                StWait: begin
                    if (!bus.OPB_select) begin
                        state_q    <= StIdle;
                        tout_sup_q <= 1'b0;
                    end else if (wait_cnt_q == 2'd0) begin
                        state_q    <= StAck;
                        tout_sup_q <= 1'b0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 2'd1;
                    end
                end
                StAck:   state_q <= StIdle;
                default: state_q <= StIdle;
            endcase

            // Strobe fires even with no byte enabled.
            if (enter_ack && !cur_rnw && !cur_err) begin
                for (int i = 0; i < C_NUM_REGS; i++) begin
                    if (cur_idx == 4'(i)) begin
                        strb_q[i] <= 1'b1;
                        for (int b = 0; b < 4; b++) begin
                            if (cur_be[b]) regs_q[i][8*b +: 8] <= cur_wdata[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        user_data_out = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            user_data_out[32*i +: 32] = C_DIR_MASK[4'(i)] ? 32'h0 : regs_q[i];
        end
    end

    assign user_wr_strb   = strb_q;
    assign bus.Sl_DBus    = rdata_q;
    assign bus.Sl_xferAck = xfer_ack_q;
    assign bus.Sl_errAck  = err_ack_q;
    assign bus.Sl_retry   = 1'b0;
    assign bus.Sl_toutSup = tout_sup_q;

    logic unused_seq_addr;
    assign unused_seq_addr = bus.OPB_seqAddr;

endmodule

// File: tb/tb_opb_register_bank.sv
// Bench for opb_register_bank: two instances (no wait states / two wait states) driven with
// directed and random transfers; a monitor checks each ack against a queued reference result.
module tb_opb_register_bank;

    localparam logic [31:0] BASE = 32'h0100_0000;
    localparam logic [31:0] HIGH = 32'h0100_00FF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n [2];
    logic [31:0]  abus  [2];
    logic         rnw   [2];
    logic [3:0]   be    [2];
    logic [31:0]  wdat  [2];
    logic         sel   [2];
    logic [127:0] din   [2];
    logic [127:0] udo   [2];
    logic [3:0]   strb  [2];
    logic         ack_w [2];
    logic         err_w [2];
    logic         tout_w [2];
    logic         retry_w [2];
    logic [31:0]  rd_w  [2];

    opb_register_bank_if bus0 ();
    opb_register_bank_if bus1 ();

    assign bus0.OPB_ABus = abus[0];
    assign bus0.OPB_BE = be[0];
    assign bus0.OPB_DBus = wdat[0];
    assign bus0.OPB_RNW = rnw[0];
    assign bus0.OPB_select = sel[0];
    assign bus0.OPB_seqAddr = 1'b0;
    assign bus1.OPB_ABus = abus[1];
    assign bus1.OPB_BE = be[1];
    assign bus1.OPB_DBus = wdat[1];
    assign bus1.OPB_RNW = rnw[1];
    assign bus1.OPB_select = sel[1];
    assign bus1.OPB_seqAddr = 1'b0;

    assign ack_w[0] = bus0.Sl_xferAck;
    assign err_w[0] = bus0.Sl_errAck;
    assign tout_w[0] = bus0.Sl_toutSup;
    assign retry_w[0] = bus0.Sl_retry;
    assign rd_w[0] = bus0.Sl_DBus;
    assign ack_w[1] = bus1.Sl_xferAck;
    assign err_w[1] = bus1.Sl_errAck;
    assign tout_w[1] = bus1.Sl_toutSup;
    assign retry_w[1] = bus1.Sl_retry;
    assign rd_w[1] = bus1.Sl_DBus;

    opb_register_bank #(
        .C_NUM_REGS (4), .C_DIR_MASK (16'h0004), .C_RESET_VAL (32'h0000_0000), .C_ACK_WAIT (0)
    ) dut0 (
        .OPB_Clk (clk), .OPB_Rst_n (rst_n[0]), .bus (bus0),
        .user_data_out (udo[0]), .user_data_in (din[0]), .user_wr_strb (strb[0])
    );

    opb_register_bank #(
        .C_NUM_REGS (4), .C_DIR_MASK (16'h0008), .C_RESET_VAL (32'h1234_ABCD), .C_ACK_WAIT (2)
    ) dut1 (
        .OPB_Clk (clk), .OPB_Rst_n (rst_n[1]), .bus (bus1),
        .user_data_out (udo[1]), .user_data_in (din[1]), .user_wr_strb (strb[1])
    );

    typedef struct {
        bit           err;
        logic [31:0]  rdata;
        logic [3:0]   strb;
        logic [127:0] udo;
        int           issue;
        int           lat;
        int           tout;
    } exp_t;

    exp_t        q0 [$];
    exp_t        q1 [$];
    logic [31:0] mreg [2][4];
    int          tout_cnt [2];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit is_ro(input int d, input int i);
        return (d == 0) ? (i == 2) : (i == 3);
    endfunction

    function automatic int waits(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    function automatic logic [31:0] rstval(input int d);
        return (d == 0) ? 32'h0000_0000 : 32'h1234_ABCD;
    endfunction

    function automatic logic [127:0] model_udo(input int d);
        logic [127:0] v = '0;
        for (int i = 0; i < 4; i++) v[32*i +: 32] = is_ro(d, i) ? 32'h0 : mreg[d][i];
        return v;
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mon(input int d);
        exp_t e;
        if (tout_w[d]) tout_cnt[d]++;
        if (ack_w[d]) begin
            if (qsize(d) == 0) begin
                checks++;
                failures++;
                $display("FAIL d%0d_unexpected_ack: got ack at cycle %0d expected none", d, cyc);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("d%0d_errack", d), 128'(err_w[d]), 128'(e.err));
                chk($sformatf("d%0d_rdata", d), 128'(rd_w[d]), 128'(e.rdata));
                chk($sformatf("d%0d_strobe", d), 128'(strb[d]), 128'(e.strb));
                chk($sformatf("d%0d_user_data_out", d), udo[d], e.udo);
                chk($sformatf("d%0d_ack_latency", d), 128'(cyc - e.issue), 128'(e.lat));
                chk($sformatf("d%0d_tout_cycles", d), 128'(tout_cnt[d]), 128'(e.tout));
            end
            tout_cnt[d] = 0;
        end else begin
            chk($sformatf("d%0d_idle_dbus", d), 128'(rd_w[d]), 128'h0);
            chk($sformatf("d%0d_idle_errack", d), 128'(err_w[d]), 128'h0);
            chk($sformatf("d%0d_idle_strobe", d), 128'(strb[d]), 128'h0);
        end
        chk($sformatf("d%0d_retry", d), 128'(retry_w[d]), 128'h0);
    endtask

    always @(negedge clk) mon(0);
    always @(negedge clk) mon(1);

    // Issue one transfer from a negedge; returns at the negedge the ack is seen.
    task automatic xfer(input int d, input logic [31:0] addr, input bit r, input logic [3:0] b,
                        input logic [31:0] data, input bit b2b, input bit chg);
        exp_t e;
        int   idx;
        bit   got;
        abus[d] = addr;
        rnw[d] = r;
        be[d] = b;
        wdat[d] = data;
        sel[d] = 1'b1;
        if (addr < BASE || addr > HIGH) begin
            repeat (4) @(negedge clk);
            return;
        end
        idx = int'((addr - BASE) >> 2);
        e.err = (idx >= 4) || (!r && is_ro(d, idx));
        e.rdata = '0;
        e.strb = '0;
        if (!e.err && r) e.rdata = is_ro(d, idx) ? din[d][32*idx +: 32] : mreg[d][idx];
        if (!e.err && !r) begin
            e.strb[idx] = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (b[k]) mreg[d][idx][8*k +: 8] = data[8*k +: 8];
            end
        end
        e.udo = model_udo(d);
        e.issue = cyc;
        e.lat = 1 + waits(d) + (b2b ? 1 : 0);
        e.tout = waits(d);
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (chg && n == 0) din[d] = ~din[d];
            got = ack_w[d];
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL d%0d_ack_timeout: got no ack in 20 cycles expected ack", d);
            if (d == 0) e = q0.pop_back(); else e = q1.pop_back();
        end
    endtask

    task automatic idle(input int d);
        sel[d] = 1'b0;
        @(negedge clk);
    endtask

    // Start a write to register 0, then kill it during WAIT by select drop or reset.
    task automatic abort_xfer(input int d, input bit use_rst);
        abus[d] = BASE;
        rnw[d] = 1'b0;
        be[d] = 4'hF;
        wdat[d] = $urandom;
        sel[d] = 1'b1;
        @(negedge clk);
        sel[d] = 1'b0;
        if (use_rst) rst_n[d] = 1'b0;
        @(negedge clk);
        if (use_rst) begin
            chk($sformatf("d%0d_tout_in_reset", d), 128'(tout_w[d]), 128'h0);
            rst_n[d] = 1'b1;
            for (int i = 0; i < 4; i++) mreg[d][i] = rstval(d);
        end
        repeat (3) @(negedge clk);
        tout_cnt[d] = 0;
        chk($sformatf("d%0d_abort_regs", d), udo[d], model_udo(d));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish by 2 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        int          d;
        int          mode;
        for (int j = 0; j < 2; j++) begin
            rst_n[j] = 1'b0;
            abus[j] = '0;
            rnw[j] = 1'b0;
            be[j] = '0;
            wdat[j] = '0;
            sel[j] = 1'b0;
            din[j] = '0;
            tout_cnt[j] = 0;
            for (int i = 0; i < 4; i++) mreg[j][i] = rstval(j);
        end
        repeat (3) @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            chk($sformatf("d%0d_reset_udo", j), udo[j], model_udo(j));
            chk($sformatf("d%0d_reset_ack", j), 128'(ack_w[j]), 128'h0);
            chk($sformatf("d%0d_reset_tout", j), 128'(tout_w[j]), 128'h0);
        end

        // No wait states, register 2 read-only.
        xfer(0, 32'h0100_0004, 1'b0, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b0); idle(0);
        xfer(0, 32'h0100_0004, 1'b0, 4'b0100, 32'h00AA_0000, 1'b0, 1'b0); idle(0);
        xfer(0, 32'h0100_0004, 1'b1, 4'hF, 32'h0, 1'b0, 1'b0); idle(0);
        din[0][95:64] = 32'h1234_5678;
        xfer(0, 32'h0100_0008, 1'b1, 4'hF, 32'h0, 1'b0, 1'b1); idle(0);
        xfer(0, 32'h0100_0008, 1'b0, 4'hF, 32'hFFFF_FFFF, 1'b0, 1'b0); idle(0);
        xfer(0, 32'h0100_000C, 1'b0, 4'b0000, 32'h5555_AAAA, 1'b0, 1'b0); idle(0);
        xfer(0, 32'h0100_000C, 1'b0, 4'hF, 32'h0BAD_F00D, 1'b0, 1'b0);
        xfer(0, 32'h0100_000C, 1'b1, 4'hF, 32'h0, 1'b1, 1'b0); idle(0);

        // Two wait states, register 3 read-only.
        xfer(1, 32'h0100_0010, 1'b1, 4'hF, 32'h0, 1'b0, 1'b0); idle(1);
        din[1][127:96] = 32'hCAFE_F00D;
        xfer(1, 32'h0100_000C, 1'b1, 4'hF, 32'h0, 1'b0, 1'b1); idle(1);
        xfer(1, 32'h0100_0008, 1'b0, 4'b1001, 32'hA1B2_C3D4, 1'b0, 1'b0); idle(1);
        abort_xfer(1, 1'b0);
        abort_xfer(1, 1'b1);
        xfer(1, 32'h0100_0000, 1'b0, 4'hF, 32'h7654_3210, 1'b0, 1'b0); idle(1);
        xfer(1, 32'h0100_0000, 1'b1, 4'hF, 32'h0, 1'b0, 1'b0); idle(1);

        for (int n = 0; n < 160; n++) begin
            d = int'($urandom_range(0, 1));
            mode = int'($urandom_range(0, 5));
            if (mode < 4) a = BASE + 32'(4 * mode);
            else if (mode == 4) a = BASE + 32'(4 * $urandom_range(4, 63));
            else if ($urandom_range(0, 1) == 1) a = BASE - 32'(4 * $urandom_range(1, 8));
            else a = HIGH + 32'd1 + 32'(4 * $urandom_range(0, 8));
            a = a + 32'($urandom_range(0, 3));
            din[d] = {$urandom, $urandom, $urandom, $urandom};
            xfer(d, a, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                 1'b0, 1'b0);
            idle(d);
        end

        repeat (4) @(negedge clk);
        chk("d0_queue_drained", 128'(qsize(0)), 128'h0);
        chk("d1_queue_drained", 128'(qsize(1)), 128'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/opb_register_bank.md
# opb_register_bank

Parametrised OPB slave register bank: the multi-register successor to the single PPC-to-Simulink register. It exposes `C_NUM_REGS` 32-bit word registers on the PowerPC OPB bus. Each register is either software-written and driven into fabric, or fabric-driven and read by software. The block adds per-register write strobes, byte-enable writes, programmable ack wait states and error acknowledge. It sits between the OPB bus and user fabric logic, wholly in the OPB clock domain.

## Interface
- `C_BASEADDR`, default 32'h01000000, base of the decoded window (word aligned).
- `C_HIGHADDR`, default 32'h010000FF, top of the decoded window.
- `C_NUM_REGS`, default 4, register count, 1..16.
- `C_DIR_MASK`, default 0, bit i=1 makes register i fabric-to-software (read-only).
- `C_RESET_VAL`, default 32'h0, reset value of every writable register.
- `C_ACK_WAIT`, default 0, extra wait cycles before `Sl_xferAck`, 0..3.
- `OPB_Clk`  in  1  sole clock.
- `OPB_Rst_n`  in  1  reset, asynchronous, active-low.
- `OPB_ABus`  in  [0:31]  address, bit 0 MSB.
- `OPB_BE`  in  [0:3]  byte enables; `BE[0]` covers `DBus[0:7]`.
- `OPB_DBus`  in  [0:31]  write data.
- `OPB_RNW`  in  1  1=read, 0=write.
- `OPB_select`  in  1  transfer request.
- `OPB_seqAddr`  in  1  ignored (every beat is a single transfer).
- `Sl_DBus`  out  [0:31]  read data; zero whenever `Sl_xferAck`=0.
- `Sl_xferAck`  out  1  transfer acknowledge, one-cycle pulse.
- `Sl_errAck`  out  1  error, coincident with `Sl_xferAck`.
- `Sl_retry`  out  1  tied 0.
- `Sl_toutSup`  out  1  high during WAIT.
- `user_data_out`  out  [32*C_NUM_REGS-1:0]  register i at bits [32i+31:32i]; read-only slots drive 0.
- `user_data_in`  in  [32*C_NUM_REGS-1:0]  fabric values for read-only registers; other slots ignored.
- `user_wr_strb`  out  [C_NUM_REGS-1:0]  bit i pulses one cycle when register i is written.

## Operation
- Hit: `OPB_select`=1 and `C_BASEADDR` ≤ `OPB_ABus` ≤ `C_HIGHADDR`. Index = (`OPB_ABus` − `C_BASEADDR`) >> 2; `ABus[30:31]` ignored.
- FSM states:
  - IDLE: on hit, latch index, RNW, BE and DBus. For reads, snapshot `user_data_in` of the addressed register. Go to WAIT if `C_ACK_WAIT`>0, else ACK.
  - WAIT: count `C_ACK_WAIT` cycles, then ACK. A drop of `OPB_select` (master abort) returns to IDLE with no ack and no write.
  - ACK: assert `Sl_xferAck` for one cycle, then IDLE unconditionally.
- Error: index ≥ `C_NUM_REGS`, or write to a read-only register, gives `Sl_errAck`=1 with `Sl_xferAck`. No register changes, no strobe, and read data is 0.
- Writes: in the ACK cycle, update only the bytes with `BE`=1. OPB `DBus[0:7]` maps to user bits [31:24], and so on down. The strobe bit fires in the same cycle even when `BE`=0000.
- Reads: `Sl_DBus` = writable register contents, or the snapshot for read-only registers, in the ACK cycle; 0 otherwise.
- Back-to-back: `OPB_select` held high after ACK is sampled in IDLE as a new transfer. No double ack is possible because ACK always exits.

## Timing
- Select sampled at edge k (IDLE). `Sl_xferAck` is high for cycle k+1+`C_ACK_WAIT` only. The next transfer is accepted at the following edge, giving a minimum 2 cycles per transfer.
- `user_data_out` and `user_wr_strb` are registered and change at the same edge that raises `Sl_xferAck`.
- All slave outputs are registered.
- Reset values:
  - `Sl_*` = 0 and `user_wr_strb` = 0.
  - Writable registers = `C_RESET_VAL`.
  - FSM in IDLE.
- Reset asserted mid-transfer: the transfer is dropped with no ack. Any write not yet acked is discarded.

## Test plan
- Reset release, `C_NUM_REGS`=4, no bus activity:
  - `user_data_out` = four copies of `C_RESET_VAL`.
  - All `Sl_*` = 0.
- Write 0xDEADBEEF with BE=1111 to 0x01000004:
  - Exactly one `Sl_xferAck` pulse, one cycle after select.
  - `user_data_out[63:32]` = 0xDEADBEEF.
  - `user_wr_strb` = 0010 for that same cycle.
- Byte-enable write: BE=0100, data 0x00AA0000, to register 1 holding 0xDEADBEEF:
  - Register 1 becomes 0xDEAABEEF.
  - Read-back returns 0xDEAABEEF on `Sl_DBus` during the ack cycle only.
- Read-only register (`C_DIR_MASK`=0100), with `user_data_in` reg 2 = 0x12345678 at select then changed:
  - Read returns 0x12345678.
  - A write to 0x01000008 gives xferAck+errAck and leaves the strobe at 0.
- `C_ACK_WAIT`=2, read of 0x01000010 (index 4 ≥ 4):
  - `Sl_toutSup` is high for 2 cycles.
  - Ack arrives at k+3 with errAck=1 and `Sl_DBus`=0.
- `OPB_Rst_n` asserted during WAIT of a write:
  - No ack, register unchanged from reset value.
  - The next transfer after release completes normally.
